fft_uart_top: RTL and testbench
===============================

Name: fft_uart_top

Overview:
- Input/output stage of the FFT sequence lab.
- Receives signed 8-bit time samples over a UART line and sign-extends each to bit_width bits.
- Buffers one frame of N samples, then streams the frame back over a UART transmitter in FFT input order (bit-reversed address order).
- Sits between the board UART pins and the FFT core; the transmit path is the debug/readback channel.

Parameters:
- bit_width, 26, stored sample width in bits (8..32).
- N, 256, frame length in samples; power of two, 4..1024.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud).

Ports:
- CLK  in  1  system clock, 50 MHz, rising edge.
- RST_N  in  1  asynchronous reset, active-HIGH despite the name; while high, all state is cleared.
- data_in  in  1  UART RX line, 8N1, LSB first, idle high; asynchronous to CLK.
- tx_o  out  1  UART TX line, 8N1, LSB first, idle high.

Behaviour:
- Reset values:
  - tx_o=1.
  - State FILL; write pointer=0; read pointer=0.
  - RX and TX bit counters=0.
  - Buffer contents are don't-care.
- RX:
  - data_in passes through a 2-flop synchronizer.
  - A start bit is a synchronized falling edge while the receiver is idle.
  - Re-check at CLKS_PER_BIT/2; if the line is high there, it is a glitch and the receiver returns to idle.
  - Data bits and the stop bit are sampled at each subsequent CLKS_PER_BIT interval.
  - Stop bit = 0 is a framing error: drop the byte and do not advance the pointer.
  - A valid byte raises a one-cycle rx_valid strobe.
- FILL:
  - On rx_valid, write sign_extend(byte, bit_width) to buf[wr_ptr] and increment wr_ptr.
  - When the write that makes wr_ptr reach N completes, go to DRAIN on the next cycle.
  - Set rd_ptr=0 and wr_ptr=0 at that transition.
- DRAIN:
  - For rd_ptr = 0..N-1, transmit word buf[bitrev(rd_ptr)], where bitrev reverses log2(N) bits.
  - Each word is zero-padded to 8*ceil(bit_width/8) bits and sent as ceil(bit_width/8) bytes, least-significant byte first.
  - With bit_width=26, -1 is sent as FF FF FF 03.
  - Bytes are back-to-back: each start bit begins the cycle after the previous stop bit ends (stop bit lasts exactly CLKS_PER_BIT cycles).
  - The first start bit begins no later than 2 cycles after entering DRAIN.
  - After the last stop bit of word N-1, return to FILL.
  - rx_valid during DRAIN is ignored (byte discarded); the RX FSM keeps running, so framing stays aligned.
- TX FSM states: IDLE, START, DATA(8 bits), STOP. tx_o is registered with no glitches.
- Reset mid-operation (async): tx_o goes high immediately, which may truncate a frame; any partial frame is lost.
- Buffer: single-port or simple dual-port RAM of N x bit_width; either registered or combinational read is acceptable if the TX timing above holds.

Optional Feature:
- Macro BITREV_EN.
- Defined: DRAIN reads in bit-reversed address order, as specified above.
- Undefined: DRAIN reads in natural order buf[rd_ptr]. All other behaviour is identical.

Decomposition:
- Package fft_uart_pkg holds:
  - state enums (FILL/DRAIN, UART IDLE/START/DATA/STOP);
  - function clog2;
  - BYTES_PER_WORD = (bit_width+7)/8 as a function;
  - function bitrev(idx, width).
- One reusable sub-module, uart_byte_tx: CLK, RST_N, start, data[7:0], busy, tx.
- The RX path, buffer and control stay in the top.

Test Plan:
- Reset: assert RST_N=1 for 1 cycle, then release. Required: tx_o=1 throughout; no start bit within 20 bit-times with no input.
- BITREV_EN defined, N=8: send bytes 00..07. Required: TX emits words in order 0,4,2,6,1,5,3,7, each as four bytes (e.g. 04 00 00 00), with back-to-back bit timing of 434 cycles.
- Sign extension, bit_width=26, N=8: send 8 bytes of FF. Required: eight words FF FF FF 03. Send 80: required word 80 FF FF 03.
- Framing error: send a byte with stop bit 0 mid-frame, then 8 valid bytes. Required: the bad byte is absent and the frame holds only the 8 valid bytes.
- Drop during DRAIN: send 3 extra bytes while transmitting. Required: output frame unchanged; the next frame starts at wr_ptr=0 with the first byte after DRAIN ends.
- Reset mid-DRAIN: assert RST_N during byte 5. Required: tx_o=1 within the same cycle; after release, a new full frame of 8 bytes is required before any TX.

Source files
------------

// File: rtl/fft_uart_pkg.sv
// fft_uart_pkg: shared constants and helpers for the FFT UART I/O stage.
//   - frame control states (FILL/DRAIN) and UART bit-phase states
//   - clog2, bytes_per_word and bitrev helper functions
package fft_uart_pkg;

    // Frame control states
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // UART bit-phase states, shared by the receiver and the transmitter
    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r = 0;
        int v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Number of UART bytes used to carry one stored word.
    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

    // Reverse the low 'width' bits of idx.
    function automatic int unsigned bitrev(input int unsigned idx, input int width);
        int unsigned r = 0;
        for (int i = 0; i < width; i++) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART byte transmitter, LSB first, idle high.
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous reset, active HIGH; forces tx high
//   start  load data and begin a frame when busy is low
//   data   byte to transmit
//   busy   high while a frame is in progress and cannot accept start
//   tx     registered serial output
module uart_byte_tx
    import fft_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CW = clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          last_tick;

    assign last_tick = (cnt == LAST);

    // The final stop-bit cycle reports not-busy so a queued byte can start on
    // the very next cycle, giving back-to-back frames.
    assign busy = (state != U_IDLE) && !(state == U_STOP && last_tick);

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            state   <= U_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else if (start && !busy) begin
            state   <= U_START;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= data;
            tx      <= 1'b0;
        end else begin
            case (state)
                U_IDLE: begin
                    tx <= 1'b1;
                end
                U_START: begin
                    if (last_tick) begin
                        cnt   <= '0;
                        state <= U_DATA;
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                U_DATA: begin
                    if (last_tick) begin
                        cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= U_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                U_STOP: begin
                    if (last_tick) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= U_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= U_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fft_uart_top.sv
// fft_uart_top: UART input/output stage of the FFT sequence lab.
// Receives signed 8-bit samples over UART, sign-extends them to bit_width bits,
// buffers a frame of N words, then streams the frame back over UART with each
// word sent as bytes_per_word(bit_width) bytes, least-significant byte first.
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous reset, active HIGH despite the name
//   data_in  UART RX line (8N1, asynchronous to CLK)
//   tx_o     UART TX line (8N1, registered)
// Build option: define BITREV_EN to read the frame in bit-reversed address
// order (FFT input order); otherwise the frame is read in natural order.
module fft_uart_top
    import fft_uart_pkg::*;
#(
    parameter int bit_width    = 26,
    parameter int N            = 256,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic data_in,
    output logic tx_o
);

    localparam int AW  = clog2(N);
    localparam int BPW = bytes_per_word(bit_width);
    localparam int PW  = 8 * BPW;
    localparam int CW  = clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(N - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(BPW - 1);

    // ---------------- RX path ----------------
    logic [1:0]    sync_q;
    logic          rx_prev;
    logic          rx_s;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_byte;
    logic          rx_valid;

    assign rx_s = sync_q[1];

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            sync_q   <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= U_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], data_in};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            case (rx_state)
                U_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= U_START;
                        rx_cnt   <= '0;
                    end
                end
                U_START: begin
                    // Mid-start re-check rejects glitches shorter than half a bit
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_s ? U_IDLE : U_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                U_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        if (rx_bits == 3'd7) begin
                            rx_state <= U_STOP;
                        end else begin
                            rx_bits <= rx_bits + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                U_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_valid <= rx_s;  // low stop bit: framing error, byte dropped
                        rx_state <= U_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= U_IDLE;
            endcase
        end
    end

    // ---------------- Frame buffer ----------------
    logic [bit_width-1:0] mem [N];
    logic [0:0]           state;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        rd_addr;
    logic [1:0]           byte_idx;
    logic                 sent_all;
    logic                 wr_en;
    logic [bit_width-1:0] wr_word;
    logic [bit_width-1:0] rd_word;
    logic [PW-1:0]        padded;
    logic [7:0]           tx_byte;
    logic                 tx_start;
    logic                 tx_busy;

    assign wr_en   = (state == ST_FILL) && rx_valid;
    assign wr_word = bit_width'($signed(rx_byte));

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

`ifdef BITREV_EN
    assign rd_addr = AW'(bitrev(32'(rd_ptr), AW));
`else
    assign rd_addr = rd_ptr;
`endif

    assign rd_word  = mem[rd_addr];
    assign padded   = PW'(rd_word);
    assign tx_byte  = 8'(padded >> {byte_idx, 3'b000});
    assign tx_start = (state == ST_DRAIN) && !sent_all && !tx_busy;

    // ---------------- Frame control ----------------
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_idx <= '0;
            sent_all <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (rx_valid) begin
                        if (wr_ptr == PTR_LAST) begin
                            state    <= ST_DRAIN;
                            wr_ptr   <= '0;
                            rd_ptr   <= '0;
                            byte_idx <= '0;
                            sent_all <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sent_all) begin
                        // busy drops in the last stop-bit cycle of the final byte
                        if (!tx_busy) begin
                            state    <= ST_FILL;
                            sent_all <= 1'b0;
                            rd_ptr   <= '0;
                        end
                    end else if (tx_start) begin
                        if (byte_idx == BYTE_LAST) begin
                            byte_idx <= '0;
                            if (rd_ptr == PTR_LAST) begin
                                sent_all <= 1'b1;
                            end else begin
                                rd_ptr <= rd_ptr + AW'(1);
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK  (CLK),
        .RST_N(RST_N),
        .start(tx_start),
        .data (tx_byte),
        .busy (tx_busy),
        .tx   (tx_o)
    );

endmodule

// File: tb/tb_fft_uart_top.sv
// tb_fft_uart_top: scoreboard bench for fft_uart_top with a short bit period.
// A UART driver sends bytes and a frame-level model pushes the expected output
// bytes; an independent UART monitor decodes tx_o and checks against the queue.
module tb_fft_uart_top;

    localparam int C   = 8;
    localparam int NW  = 8;
    localparam int BW  = 26;
    localparam int BPW = (BW + 7) / 8;
    localparam int FB  = NW * BPW;

    logic CLK     = 1'b0;
    logic RST_N   = 1'b1;
    logic data_in = 1'b1;
    logic tx_o;

    fft_uart_top #(
        .bit_width   (BW),
        .N           (NW),
        .CLKS_PER_BIT(C)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .data_in(data_in),
        .tx_o   (tx_o)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(negedge CLK) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frame_in[$];
    bit         drain_active = 1'b0;
    int         epoch        = 0;
    int         mon_idx      = 0;
    int         starts       = 0;
    int         stop_mid_cyc = 0;
    int         prev_start   = 0;
    int         order[NW];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Stored word value of a received byte: signed byte taken modulo 2^BW.
    function automatic int word_of(input logic [7:0] b);
        int s;
        s = (int'(b) > 127) ? int'(b) - 256 : int'(b);
        if (s < 0) s = s + (1 << BW);
        return s;
    endfunction

    task automatic push_frame();
        int w;
        for (int i = 0; i < NW; i++) begin
            w = word_of(frame_in[order[i]]);
            for (int b = 0; b < BPW; b++) begin
                exp_q.push_back(8'((w >> (8 * b)) & 255));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        data_in = 1'b0;
        repeat (C) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
            repeat (C) @(negedge CLK);
        end
        data_in = stop;
        repeat (C / 2) @(negedge CLK);
        stop_mid_cyc = cyc;
        repeat (C - C / 2) @(negedge CLK);
        data_in = 1'b1;
        if (!stop) repeat (2 * C) @(negedge CLK);
        if (stop && !drain_active) begin
            frame_in.push_back(b);
            if (frame_in.size() == NW) begin
                push_frame();
                frame_in.delete();
                drain_active = 1'b1;
            end
        end
    endtask

    task automatic send_random(input int count);
        for (int i = 0; i < count; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < FB * 10 * C + 400 && exp_q.size() != 0; i++) @(negedge CLK);
        chk(name, exp_q.size(), 0);
        repeat (3 * C) @(negedge CLK);
    endtask

    // UART monitor on tx_o
    initial begin : monitor
        forever begin
            logic [7:0] got;
            logic [7:0] expv;
            logic       sb;
            logic       pb;
            int         t0;
            int         ep;
            @(negedge tx_o);
            t0 = cyc;
            ep = epoch;
            starts++;
            if (mon_idx == 0) chk_range("first_start_latency", t0 - stop_mid_cyc, 0, 8);
            else chk("byte_gap_cycles", t0 - prev_start, 10 * C);
            prev_start = t0;
            repeat (C / 2) @(posedge CLK);
            #1 sb = tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(posedge CLK);
                #1 got[i] = tx_o;
            end
            repeat (C) @(posedge CLK);
            #1 pb = tx_o;
            if (ep == epoch) begin
                chk("start_bit", int'(sb), 0);
                chk("stop_bit", int'(pb), 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx_byte: got 0x%0h, required no byte", got);
                end else begin
                    expv = exp_q.pop_front();
                    chk("tx_byte", int'(got), int'(expv));
                end
                mon_idx = (mon_idx + 1) % FB;
                if (exp_q.size() == 0) drain_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish within 90000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int bad;
        int found;
        int s0;
`ifdef BITREV_EN
        order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        // Reset for one cycle, then no activity for 20 bit-times
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        chk("tx_after_reset", int'(tx_o), 1);
        bad = 0;
        repeat (20 * C) begin
            @(negedge CLK);
            if (tx_o !== 1'b1) bad++;
        end
        chk("tx_idle_low_cycles", bad, 0);
        chk("starts_while_idle", starts, 0);

        // Ordered ramp frame
        for (int i = 0; i < NW; i++) send_byte(8'(i), 1'b1);
        wait_drain("drain_ramp");

        // Sign extension of all-ones
        for (int i = 0; i < NW; i++) send_byte(8'hFF, 1'b1);
        wait_drain("drain_ff");

        // Most negative byte plus random fill
        send_byte(8'h80, 1'b1);
        send_random(NW - 1);
        wait_drain("drain_80");

        // Framing error mid-frame
        send_random(3);
        send_byte(8'h5A, 1'b0);
        send_random(NW - 3);
        wait_drain("drain_framing");

        // Bytes received during DRAIN are discarded
        send_random(NW);
        send_random(3);
        wait_drain("drain_drop");
        send_random(NW);
        wait_drain("drain_after_drop");

        // Reset during the sixth transmitted byte
        send_random(NW);
        found = 0;
        for (int i = 0; i < FB * 10 * C && found == 0; i++) begin
            @(negedge CLK);
            if (mon_idx == 5 && tx_o == 1'b0) found = 1;
        end
        chk("reached_byte5", found, 1);
        RST_N = 1'b1;
        epoch++;
        exp_q.delete();
        frame_in.delete();
        drain_active = 1'b0;
        mon_idx = 0;
        #1 chk("tx_high_on_reset", int'(tx_o), 1);
        @(negedge CLK);
        RST_N = 1'b0;
        s0 = starts;
        repeat (20 * C) @(negedge CLK);
        chk("no_tx_after_reset", starts - s0, 0);
        send_random(NW - 1);
        repeat (2 * C) @(negedge CLK);
        chk("no_tx_partial_frame", starts - s0, 0);
        send_random(1);
        wait_drain("drain_after_reset");

        // Random frames
        send_random(NW);
        wait_drain("drain_rand1");
        send_random(NW);
        wait_drain("drain_rand2");

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
